// File: rtl/fw_hex_loader_pkg.sv
// Shared definitions for the Intel-HEX firmware loader: record types,
// error codes, loader state encoding and a small character helper.
package fw_hex_loader_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_REG_WIDTH  = 8;

  localparam logic [7:0] HEX_TYPE_DATA = 8'h00;
  localparam logic [7:0] HEX_TYPE_EOF  = 8'h01;

  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL_CHAR = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM     = 2'd2;
  localparam logic [1:0] ERR_UNSUPPORTED  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_COUNT,
    ST_ADDR,
    ST_TYPE,
    ST_DATA,
    ST_CSUM,
    ST_CHECK,
    ST_COMMIT,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  // Whitespace tolerated between records: CR, LF and space.
  function automatic logic is_blank(input logic [7:0] c);
    return (c == 8'h0D) || (c == 8'h0A) || (c == 8'h20);
  endfunction

endpackage

// File: rtl/fw_hex_loader_hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: accepts 0-9, A-F and a-f.
module hex_ascii_decode (
  input  logic [7:0] char_in,
  output logic       valid,
  output logic [3:0] nibble
);

  // Map one ASCII character to its nibble value, flagging non-hex input.
  always_comb begin
    valid  = 1'b0;
    nibble = 4'h0;
    if (char_in >= 8'h30 && char_in <= 8'h39) begin
      valid  = 1'b1;
      nibble = 4'(char_in - 8'h30);
    end else if (char_in >= 8'h41 && char_in <= 8'h46) begin
      valid  = 1'b1;
      nibble = 4'(char_in - 8'h37);
    end else if (char_in >= 8'h61 && char_in <= 8'h66) begin
      valid  = 1'b1;
      nibble = 4'(char_in - 8'h57);
    end
  end

endmodule

// File: rtl/fw_hex_loader.sv
// Intel-HEX firmware loader: parses an ASCII record stream, verifies each
// record's checksum, replays good data records into memory one byte per
// cycle and releases the CPU reset once the EOF record is accepted.
module fw_hex_loader
  import fw_hex_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_REG_WIDTH,
  parameter int MAX_REC    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  cpu_reset_n,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [15:0]           rec_count
);

  localparam int IDX_W  = $clog2(MAX_REC) + 1;
  localparam int BUF_AW = (MAX_REC > 1) ? $clog2(MAX_REC) : 1;
  localparam logic [8:0] MAX_REC_LIM = 9'(MAX_REC);

  loader_state_t   state;
  logic [7:0]      sum_reg;
  logic [3:0]      hi_nib_reg;
  logic            phase_reg;     // 1 once the high nibble of a byte is held
  logic [IDX_W-1:0] count_reg;
  logic [IDX_W-1:0] idx_reg;      // address byte / data byte / commit index
  logic [15:0]     base_reg;
  logic [7:0]      type_reg;
  logic [DATA_WIDTH-1:0] rec_buf [MAX_REC];

  logic       hex_valid;
  logic [3:0] hex_nib;
  logic [7:0] cur_byte;
  logic       accept;
  logic       buf_we;

  hex_ascii_decode u_decode (
    .char_in (char_in),
    .valid   (hex_valid),
    .nibble  (hex_nib)
  );

  assign char_ready = !(state inside {ST_CHECK, ST_COMMIT, ST_DONE});
  assign accept     = char_valid && char_ready;
  assign cur_byte   = {hi_nib_reg, hex_nib};
  assign buf_we     = accept && hex_valid && phase_reg && (state == ST_DATA);

  // Record buffer: captures each completed data byte at its index.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      rec_buf[idx_reg[BUF_AW-1:0]] <= DATA_WIDTH'(cur_byte);
    end
  end

  // Loader FSM: parse, checksum, commit, and drive all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      sum_reg     <= 8'h00;
      hi_nib_reg  <= 4'h0;
      phase_reg   <= 1'b0;
      count_reg   <= '0;
      idx_reg     <= '0;
      base_reg    <= 16'h0000;
      type_reg    <= 8'h00;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      cpu_reset_n <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
      rec_count   <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (char_in == 8'h3A) begin
              state     <= ST_COUNT;
              sum_reg   <= 8'h00;
              phase_reg <= 1'b0;
            end else if (!is_blank(char_in)) begin
              state    <= ST_ERR;
              error    <= 1'b1;
              err_code <= ERR_ILLEGAL_CHAR;
            end
          end
        end

        ST_COUNT, ST_ADDR, ST_TYPE, ST_DATA, ST_CSUM: begin
          if (accept) begin
            if (!hex_valid) begin
              state    <= ST_ERR;
              error    <= 1'b1;
              err_code <= ERR_ILLEGAL_CHAR;
            end else if (!phase_reg) begin
              hi_nib_reg <= hex_nib;
              phase_reg  <= 1'b1;
            end else begin
              phase_reg <= 1'b0;
              sum_reg   <= sum_reg + cur_byte;
              case (state)
                ST_COUNT: begin
                  if ({1'b0, cur_byte} > MAX_REC_LIM) begin
                    state    <= ST_ERR;
                    error    <= 1'b1;
                    err_code <= ERR_UNSUPPORTED;
                  end else begin
                    count_reg <= IDX_W'(cur_byte);
                    idx_reg   <= '0;
                    state     <= ST_ADDR;
                  end
                end
                ST_ADDR: begin
                  // Big-endian: the first byte shifts up into the high half.
                  base_reg <= {base_reg[7:0], cur_byte};
                  idx_reg  <= idx_reg + 1'b1;
                  if (idx_reg != '0) state <= ST_TYPE;
                end
                ST_TYPE: begin
                  type_reg <= cur_byte;
                  idx_reg  <= '0;
                  if (cur_byte != HEX_TYPE_DATA && cur_byte != HEX_TYPE_EOF) begin
                    state    <= ST_ERR;
                    error    <= 1'b1;
                    err_code <= ERR_UNSUPPORTED;
                  end else if (count_reg == '0) begin
                    state <= ST_CSUM;
                  end else begin
                    state <= ST_DATA;
                  end
                end
                ST_DATA: begin
                  idx_reg <= idx_reg + 1'b1;
                  if (idx_reg == count_reg - 1'b1) state <= ST_CSUM;
                end
                default: state <= ST_CHECK;
              endcase
            end
          end
        end

        ST_CHECK: begin
          if (sum_reg != 8'h00) begin
            state    <= ST_ERR;
            error    <= 1'b1;
            err_code <= ERR_CHECKSUM;
          end else if (type_reg == HEX_TYPE_EOF) begin
            state       <= ST_DONE;
            done        <= 1'b1;
            cpu_reset_n <= 1'b1;
          end else if (count_reg == '0) begin
            state     <= ST_IDLE;
            rec_count <= (rec_count == 16'hFFFF) ? rec_count : rec_count + 16'd1;
          end else begin
            state    <= ST_COMMIT;
            mem_we   <= 1'b1;
            mem_addr <= ADDR_WIDTH'(base_reg);
            mem_din  <= rec_buf[0];
            idx_reg  <= IDX_W'(1);
          end
        end

        ST_COMMIT: begin
          if (idx_reg == count_reg) begin
            mem_we    <= 1'b0;
            state     <= ST_IDLE;
            rec_count <= (rec_count == 16'hFFFF) ? rec_count : rec_count + 16'd1;
          end else begin
            // Address increments modulo 2^ADDR_WIDTH, so records may wrap.
            mem_addr <= mem_addr + 1'b1;
            mem_din  <= rec_buf[idx_reg[BUF_AW-1:0]];
            idx_reg  <= idx_reg + 1'b1;
          end
        end

        ST_DONE, ST_ERR: begin
          // Terminal until reset; ERR keeps char_ready high to drain input.
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fw_hex_loader.sv
// Self-checking bench for fw_hex_loader: expected memory writes are queued
// as records are generated, and a monitor pops and compares them whenever
// the loader strobes mem_we.
module tb_fw_hex_loader;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        cpu_reset_n;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] rec_count;

  int   tests = 0;
  int   failed = 0;
  int   exp_rec = 0;
  bit   gaps_en = 1'b0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [7:0] rec_q[$];
  logic [7:0] blanks[3] = '{8'h0D, 8'h0A, 8'h20};

  always #5 clk = ~clk;

  fw_hex_loader #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .MAX_REC(16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .cpu_reset_n (cpu_reset_n),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .rec_count   (rec_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_write: got addr=%h din=%h, expected no write", mem_addr, mem_din);
      end else begin
        mon_e = exp_q.pop_front();
        $display("[TB] write %h <= %h (expected %h <= %h)", mem_addr, mem_din, mon_e.addr, mon_e.data);
        chk("write_addr", 32'(mem_addr), 32'(mon_e.addr));
        chk("write_data", 32'(mem_din), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] hex_char(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (lower ? 8'h61 : 8'h41) + 8'(n - 4'd10);
  endfunction

  task automatic send_char(input logic [7:0] c);
    int n;
    @(negedge clk);
    if (gaps_en && $urandom_range(0, 2) == 0) begin
      char_valid = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    char_in = c;
    char_valid = 1'b1;
    n = 0;
    while (!char_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("char_ready_timeout", 32'(char_ready), 32'd1);
  endtask

  task automatic stop_valid();
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  // Long stall mid-record: nothing may be written or flagged meanwhile.
  task automatic hold(input int cycles);
    int we_seen;
    we_seen = 0;
    @(negedge clk);
    char_valid = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (mem_we) we_seen++;
    end
    chk("hold_no_write", 32'(we_seen), 32'd0);
    chk("hold_ready", 32'(char_ready), 32'd1);
    chk("hold_no_error", 32'(error), 32'd0);
  endtask

  // Build a record into rec_q; good data records also queue their writes.
  task automatic build_rec(input int cnt, input logic [15:0] base, input logic [7:0] typ);
    logic [7:0] s;
    logic [7:0] d;
    rec_q.delete();
    rec_q.push_back(8'(cnt));
    rec_q.push_back(base[15:8]);
    rec_q.push_back(base[7:0]);
    rec_q.push_back(typ);
    for (int i = 0; i < cnt; i++) begin
      d = 8'($urandom);
      rec_q.push_back(d);
      if (typ == 8'h00) exp_q.push_back({16'(base + 16'(i)), d});
    end
    s = 8'h00;
    foreach (rec_q[i]) s = s + rec_q[i];
    rec_q.push_back(8'(~s + 8'd1));
    if (typ == 8'h00) exp_rec++;
  endtask

  task automatic send_rec(input int hold_at);
    int k;
    k = 0;
    if (gaps_en) repeat ($urandom_range(0, 3)) send_char(blanks[$urandom_range(0, 2)]);
    send_char(8'h3A);
    foreach (rec_q[i]) begin
      for (int h = 0; h < 2; h++) begin
        if (k == hold_at) hold(120);
        send_char(hex_char((h == 0) ? rec_q[i][7:4] : rec_q[i][3:0], $urandom_range(0, 1) == 1));
        k++;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !char_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_values();
    chk("rst_char_ready", 32'(char_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    chk("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_rec_count", 32'(rec_count), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    char_valid = 1'b0;
    exp_q.delete();
    exp_rec = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  string err_str[5] = '{":0300300002337A1F", ":0300G0", ":11", ":00000002FE", "x"};
  int    err_exp[5] = '{2, 1, 3, 3, 1};

  initial begin
    int n;

    // Reset state.
    do_reset();
    chk_reset_values();

    // Reference record, with exact commit timing.
    gaps_en = 1'b0;
    exp_q.push_back({16'h0030, 8'h02});
    exp_q.push_back({16'h0031, 8'h33});
    exp_q.push_back({16'h0032, 8'h7A});
    exp_rec++;
    send_str(":0300300002337A1E");
    @(negedge clk);
    char_valid = 1'b0;
    chk("check_cycle_we", 32'(mem_we), 32'd0);
    chk("check_cycle_ready", 32'(char_ready), 32'd0);
    @(negedge clk);
    n = 0;
    while (mem_we && n < 40) begin
      chk("commit_ready_low", 32'(char_ready), 32'd0);
      n++;
      @(negedge clk);
    end
    chk("we_run_length", 32'(n), 32'd3);
    chk("ready_after_commit", 32'(char_ready), 32'd1);
    wait_drain("drain_first");
    chk("rec_count_first", 32'(rec_count), 32'd1);

    // Random records with blanks, gaps and a long mid-DATA hold.
    gaps_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      build_rec($urandom_range(0, 16), 16'($urandom), 8'h00);
      send_rec(-1);
    end
    build_rec(8, 16'($urandom), 8'h00);
    send_rec(11);
    send_char(8'h0D);
    send_char(8'h0A);
    send_char(8'h20);
    exp_q.push_back({16'h0030, 8'h02});
    exp_q.push_back({16'h0031, 8'h33});
    exp_q.push_back({16'h0032, 8'h7A});
    exp_rec++;
    send_str(":0300300002337A1E");
    stop_valid();
    wait_drain("drain_random");
    chk("rec_count_random", 32'(rec_count), 32'(exp_rec));
    chk("error_random", 32'(error), 32'd0);
    chk("cpu_reset_before_eof", 32'(cpu_reset_n), 32'd0);

    // EOF: done and cpu_reset_n rise together, two cycles after the last char.
    gaps_en = 1'b0;
    send_str(":00000001FF");
    @(negedge clk);
    char_valid = 1'b0;
    chk("eof_check_cycle_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("eof_done", 32'(done), 32'd1);
    chk("eof_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
    chk("eof_char_ready", 32'(char_ready), 32'd0);
    chk("eof_error", 32'(error), 32'd0);
    chk("eof_rec_count", 32'(rec_count), 32'(exp_rec));

    // Lowercase digits and address wrap.
    do_reset();
    exp_q.push_back({16'hFFFF, 8'hAA});
    exp_q.push_back({16'h0000, 8'hBB});
    exp_rec = 1;
    send_str(":02ffff00aabb9b");
    stop_valid();
    wait_drain("drain_wrap");
    chk("rec_count_wrap", 32'(rec_count), 32'd1);

    // Error table: each must latch its code, keep the CPU in reset and drain input.
    for (int e = 0; e < 5; e++) begin
      do_reset();
      send_str(err_str[e]);
      stop_valid();
      repeat (2) @(negedge clk);
      chk("err_flag", 32'(error), 32'd1);
      chk("err_code", 32'(err_code), 32'(err_exp[e]));
      chk("err_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
      send_str(":0300300002337A1E");
      stop_valid();
      repeat (5) @(negedge clk);
      chk("err_drain_ready", 32'(char_ready), 32'd1);
      chk("err_code_held", 32'(err_code), 32'(err_exp[e]));
      chk("err_no_commit", 32'(rec_count), 32'd0);
    end

    // Asynchronous reset in the middle of a 16-byte commit.
    do_reset();
    build_rec(2, 16'($urandom), 8'h00);
    send_rec(-1);
    stop_valid();
    wait_drain("drain_pre_abort");
    chk("rec_count_pre_abort", 32'(rec_count), 32'd1);
    build_rec(16, 16'($urandom), 8'h00);
    send_rec(-1);
    stop_valid();
    n = 0;
    while (!mem_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_commit_started", 32'(mem_we), 32'd1);
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    exp_rec = 0;
    #1;
    chk_reset_values();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    build_rec(5, 16'($urandom), 8'h00);
    send_rec(-1);
    stop_valid();
    wait_drain("drain_post_abort");
    chk("rec_count_post_abort", 32'(rec_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
